pcm_fifo_param: RTL and testbench
=================================

PCM_FIFO_PARAM -- requirements
Module: pcm_fifo_param

Interface
REQ-001 Parameter ABITS, default 4, address width; depth = 2**ABITS words, all usable.
REQ-002 Parameter DBITS, default 8, data word width.
REQ-003 Parameter AF_LEVEL, default 2**ABITS-2, almost_full threshold.
REQ-004 Parameter AE_LEVEL, default 2, almost_empty threshold.
REQ-005 clock  input  1  single clock; all logic on rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 wr  input  1  write request.
REQ-008 rd  input  1  read request.
REQ-009 clr_err  input  1  synchronous clear of sticky error flags.
REQ-010 din  input  DBITS  write data.
REQ-011 dout  output  DBITS  registered read data.
REQ-012 dout_valid  output  1  one-cycle strobe, dout updated.
REQ-013 empty / full  output  1 each  occupancy == 0 / == 2**ABITS.
REQ-014 almost_empty / almost_full  output  1 each  level <= AE_LEVEL / level >= AF_LEVEL.
REQ-015 level  output  ABITS+1  stored word count, 0..2**ABITS.
REQ-016 overflow / underflow  output  1 each  sticky error flags.
REQ-017 ready  output  1  low in reset, high from first clock edge after reset release.

Function
REQ-018 Write op (wop) and read op (rop) SHALL be derived from wr/rd per REQ-034/035; the accepted write is wacc, the accepted read is racc.
REQ-019 wacc = wop & (~full | rop); racc = rop & ~empty.
REQ-020 On wacc, din SHALL be stored at wr_ptr and wr_ptr SHALL increment modulo 2**ABITS.
REQ-021 On racc, mem[rd_ptr] SHALL be registered to dout at the same edge, with dout_valid high the following cycle only; rd_ptr SHALL increment modulo 2**ABITS.
REQ-022 Read latency SHALL be 1 clock; dout SHALL hold its value when no racc occurs.
REQ-023 level SHALL increment on wacc only, decrement on racc only, and remain unchanged on both or neither.
REQ-024 empty, full, almost_* SHALL be registered and consistent with level in the same cycle.
REQ-025 When full and wop & rop are both set, both SHALL be accepted; the read returns the oldest word (read-before-write), level stays 2**ABITS.
REQ-026 When empty and wop & rop are both set, only the write SHALL be accepted; underflow SHALL be set; level becomes 1.
REQ-027 A wop while full without rop SHALL be dropped, memory and pointers unchanged, overflow set.
REQ-028 A rop while empty SHALL be dropped, dout unchanged, dout_valid low, underflow set.
REQ-029 overflow/underflow SHALL remain set until reset or clr_err; a same-cycle new error SHALL win over clr_err.
REQ-030 Pointer wrap SHALL be seamless; full/empty SHALL be decided from level, not pointer equality.

Reset
REQ-031 On reset: wr_ptr = rd_ptr = 0, level = 0, empty = 1, almost_empty = 1, full = 0, almost_full = 0, overflow = underflow = 0, dout = 0, dout_valid = 0, ready = 0.
REQ-032 Reset asserted mid-operation SHALL discard all stored words immediately; memory contents need not be cleared.
REQ-033 Edge-detect history registers SHALL reset to 0.

Configuration
REQ-034 With macro PCM_FIFO_EDGE_DET_EN defined: wop = wr rising edge and rop = rd rising edge (one op per assertion, registered previous-value detect). A held level produces exactly one op.
REQ-035 Without PCM_FIFO_EDGE_DET_EN: wop = wr and rop = rd, sampled every clock (one op per high cycle).

Verification
REQ-036 ABITS=2, DBITS=8, no macro: write 0x11,0x22,0x33,0x44 -> full=1, level=4; 5th write 0x55 -> overflow=1, data dropped; four reads -> dout 0x11,0x22,0x33,0x44 at 1-cycle latency, then empty=1.
REQ-037 Empty FIFO, rd only -> underflow=1, dout_valid=0; then clr_err -> underflow=0.
REQ-038 Full FIFO (0x11..0x44), wr=rd=1 with din=0xAA -> dout=0x11, level=4; then drain -> 0x22,0x33,0x44,0xAA.
REQ-039 Empty FIFO, wr=rd=1 with din=0x5A -> level=1, underflow=1; next read -> 0x5A.
REQ-040 Macro defined: wr held high 10 cycles with din=0x7E -> level=1; ten write/read cycles crossing pointer wrap -> data order preserved, almost_full/almost_empty track AF_LEVEL=2/AE_LEVEL=2.
REQ-041 Reset asserted with level=3 -> next cycle level=0, empty=1, ready=0; after release ready=1 on first edge.

Source files
------------

// File: rtl/pcm_fifo_param.sv
// Single-clock FIFO with registered read data, level-derived status flags and
// sticky overflow/underflow. Define PCM_FIFO_EDGE_DET_EN to turn wr/rd into edge-triggered requests.
module pcm_fifo_param #(
  parameter int ABITS    = 4,
  parameter int DBITS    = 8,
  parameter int AF_LEVEL = 2**ABITS - 2,
  parameter int AE_LEVEL = 2
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic             i_wr,
  input  logic             i_rd,
  input  logic             i_clr_err,
  input  logic [DBITS-1:0] i_din,
  output logic [DBITS-1:0] o_dout,
  output logic             o_dout_valid,
  output logic             o_empty,
  output logic             o_full,
  output logic             o_almost_empty,
  output logic             o_almost_full,
  output logic [ABITS:0]   o_level,
  output logic             o_overflow,
  output logic             o_underflow,
  output logic             o_ready
);

  localparam int              DEPTH    = 2**ABITS;
  localparam logic [ABITS:0]  LP_DEPTH = (ABITS+1)'(DEPTH);
  localparam logic [ABITS:0]  LP_AF    = (ABITS+1)'(AF_LEVEL);
  localparam logic [ABITS:0]  LP_AE    = (ABITS+1)'(AE_LEVEL);
  localparam logic [ABITS:0]  LP_ONE   = (ABITS+1)'(1);

  logic [DBITS-1:0] r_mem [DEPTH];
  logic [ABITS-1:0] r_wr_ptr;
  logic [ABITS-1:0] r_rd_ptr;

  logic             w_wop;
  logic             w_rop;
  logic             w_wacc;
  logic             w_racc;
  logic             w_ovf_set;
  logic             w_udf_set;
  logic [ABITS:0]   w_level_nxt;

`ifdef PCM_FIFO_EDGE_DET_EN
  logic r_wr_d;
  logic r_rd_d;

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_wr_d <= 1'b0;
      r_rd_d <= 1'b0;
    end else begin
      r_wr_d <= i_wr;
      r_rd_d <= i_rd;
    end
  end

  assign w_wop = i_wr & ~r_wr_d;
  assign w_rop = i_rd & ~r_rd_d;
`else
  assign w_wop = i_wr;
  assign w_rop = i_rd;
`endif

  // A write while full is still taken when a read frees the slot in the same edge.
  always_comb begin
    w_racc      = w_rop & ~o_empty;
    w_wacc      = w_wop & (~o_full | w_rop);
    w_ovf_set   = w_wop & o_full & ~w_rop;
    w_udf_set   = w_rop & o_empty;
    w_level_nxt = o_level;
    if (w_wacc && !w_racc) begin
      w_level_nxt = o_level + LP_ONE;
    end else if (!w_wacc && w_racc) begin
      w_level_nxt = o_level - LP_ONE;
    end
  end

  always_ff @(posedge i_clock) begin
    if (w_wacc) begin
      r_mem[r_wr_ptr] <= i_din;
    end
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_wr_ptr       <= '0;
      r_rd_ptr       <= '0;
      o_level        <= '0;
      o_empty        <= 1'b1;
      o_almost_empty <= 1'b1;
      o_full         <= 1'b0;
      o_almost_full  <= 1'b0;
      o_overflow     <= 1'b0;
      o_underflow    <= 1'b0;
      o_dout         <= '0;
      o_dout_valid   <= 1'b0;
      o_ready        <= 1'b0;
    end else begin
      o_ready      <= 1'b1;
      o_dout_valid <= w_racc;
      if (w_wacc) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_racc) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
        o_dout   <= r_mem[r_rd_ptr];
      end
      o_level        <= w_level_nxt;
      o_empty        <= (w_level_nxt == '0);
      o_full         <= (w_level_nxt == LP_DEPTH);
      o_almost_empty <= (w_level_nxt <= LP_AE);
      o_almost_full  <= (w_level_nxt >= LP_AF);
      // A new error in the same cycle takes priority over the clear.
      if (w_ovf_set) begin
        o_overflow <= 1'b1;
      end else if (i_clr_err) begin
        o_overflow <= 1'b0;
      end
      if (w_udf_set) begin
        o_underflow <= 1'b1;
      end else if (i_clr_err) begin
        o_underflow <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pcm_fifo_param.sv
// Scoreboard bench for pcm_fifo_param (ABITS=2, DBITS=8); covers edge-detect mode
// when PCM_FIFO_EDGE_DET_EN is defined.
module tb_pcm_fifo_param;

  localparam int ABITS = 2;
  localparam int DBITS = 8;
  localparam int DEPTH = 4;
  localparam int AFL   = 2;
  localparam int AEL   = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             wr, rd, clr;
  logic [DBITS-1:0] din;
  logic [DBITS-1:0] dout;
  logic             dv, empty, full, aempty, afull, ovf, udf, ready;
  logic [ABITS:0]   level;

  pcm_fifo_param #(.ABITS(ABITS), .DBITS(DBITS), .AF_LEVEL(AFL), .AE_LEVEL(AEL)) dut (
    .i_clock(clk), .i_reset(rst), .i_wr(wr), .i_rd(rd), .i_clr_err(clr), .i_din(din),
    .o_dout(dout), .o_dout_valid(dv), .o_empty(empty), .o_full(full),
    .o_almost_empty(aempty), .o_almost_full(afull), .o_level(level),
    .o_overflow(ovf), .o_underflow(udf), .o_ready(ready)
  );

  always #5 clk = ~clk;

  int unsigned n_vec  = 0;
  int unsigned n_miss = 0;

  logic [7:0] mq [$];
  logic [7:0] sb [$];
  logic       m_valid, m_ovf, m_udf, m_ready, pw, pr;
  logic [7:0] m_dout;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete(); sb.delete();
    m_valid = 0; m_ovf = 0; m_udf = 0; m_ready = 0; pw = 0; pr = 0; m_dout = '0;
  endtask

  task automatic check_all();
    logic [7:0] e;
    chk("level", 32'(level), 32'(mq.size()));
    chk("empty", 32'(empty), 32'(mq.size() == 0));
    chk("full", 32'(full), 32'(mq.size() == DEPTH));
    chk("almost_empty", 32'(aempty), 32'(mq.size() <= AEL));
    chk("almost_full", 32'(afull), 32'(mq.size() >= AFL));
    chk("overflow", 32'(ovf), 32'(m_ovf));
    chk("underflow", 32'(udf), 32'(m_udf));
    chk("ready", 32'(ready), 32'(m_ready));
    chk("dout_valid", 32'(dv), 32'(m_valid));
    if (dv) begin
      if (sb.size() == 0) chk("dout_unexpected", 32'(dout), 32'hFFFF_FFFF);
      else begin
        e = sb.pop_front();
        chk("dout", 32'(dout), 32'(e));
      end
    end
    chk("dout_hold", 32'(dout), 32'(m_dout));
  endtask

  // One clock: drive at negedge, update model for the coming edge, check after it.
  task automatic step(input logic w, input logic r, input logic [7:0] d, input logic c);
    logic wop, rop, fl, em, racc, wacc;
    @(negedge clk);
    wr = w; rd = r; din = d; clr = c;
`ifdef PCM_FIFO_EDGE_DET_EN
    wop = w & ~pw; rop = r & ~pr;
`else
    wop = w; rop = r;
`endif
    pw = w; pr = r;
    fl = (mq.size() == DEPTH);
    em = (mq.size() == 0);
    racc = rop & ~em;
    wacc = wop & (~fl | rop);
    m_valid = racc;
    if (racc) begin
      m_dout = mq.pop_front();
      sb.push_back(m_dout);
    end
    if (wacc) mq.push_back(d);
    if (wop & fl & ~rop) m_ovf = 1; else if (c) m_ovf = 0;
    if (rop & em) m_udf = 1; else if (c) m_udf = 0;
    m_ready = 1;
    @(posedge clk);
    #1;
    check_all();
  endtask

  // A single operation; in edge-detect mode the request is released afterwards.
  task automatic op(input logic w, input logic r, input logic [7:0] d);
    step(w, r, d, 1'b0);
`ifdef PCM_FIFO_EDGE_DET_EN
    step(1'b0, 1'b0, 8'h00, 1'b0);
`endif
  endtask

  task automatic fill4();
    op(1, 0, 8'h11); op(1, 0, 8'h22); op(1, 0, 8'h33); op(1, 0, 8'h44);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1; wr = 0; rd = 0; clr = 0; din = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    @(negedge clk);
    rst = 0;
    step(0, 0, 0, 0);

    // Fill, overflow, drain.
    fill4();
    chk("full_after_fill", 32'(full), 32'd1);
    chk("level_after_fill", 32'(level), 32'd4);
    op(1, 0, 8'h55);
    chk("overflow_set", 32'(ovf), 32'd1);
    repeat (4) op(0, 1, 0);
    chk("empty_after_drain", 32'(empty), 32'd1);
    step(0, 0, 0, 1);

    // Underflow on empty read, then clear.
    op(0, 1, 0);
    chk("underflow_set", 32'(udf), 32'd1);
    step(0, 0, 0, 1);
    chk("underflow_cleared", 32'(udf), 32'd0);

    // Simultaneous write+read while full.
    fill4();
    op(1, 1, 8'hAA);
    chk("full_wr_rd_dout", 32'(dout), 32'h11);
    chk("full_wr_rd_level", 32'(level), 32'd4);
    repeat (4) op(0, 1, 0);

    // Simultaneous write+read while empty.
    op(1, 1, 8'h5A);
    chk("empty_wr_rd_level", 32'(level), 32'd1);
    op(0, 1, 0);
    chk("empty_wr_rd_data", 32'(dout), 32'h5A);

    // Error raised in the same cycle as clr_err must stay set.
    step(0, 1, 0, 1);
    chk("err_beats_clr", 32'(udf), 32'd1);
    step(0, 0, 0, 1);

`ifdef PCM_FIFO_EDGE_DET_EN
    repeat (10) step(1, 0, 8'h7E, 0);
    chk("held_wr_level", 32'(level), 32'd1);
    step(0, 0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      op(1, 0, 8'(8'hC0 + i));
      op(0, 1, 0);
    end
`endif

    // Random traffic across many pointer wraps.
    for (int i = 0; i < 300; i++) begin
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           8'($urandom), 1'($urandom_range(0, 7) == 0));
    end
    step(0, 0, 0, 1);
    while (mq.size() != 0) op(0, 1, 0);

    // Reset mid-operation with three words stored.
    op(1, 0, 8'h01); op(1, 0, 8'h02); op(1, 0, 8'h03);
    chk("pre_reset_level", 32'(level), 32'd3);
    @(negedge clk);
    wr = 0; rd = 0; clr = 0;
    rst = 1;
    model_reset();
    #1;
    check_all();
    @(posedge clk);
    #1;
    check_all();
    @(negedge clk);
    rst = 0;
    step(0, 0, 0, 0);
    chk("ready_after_release", 32'(ready), 32'd1);
    op(1, 0, 8'h9C);
    op(0, 1, 0);
    step(0, 0, 0, 0);

    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
